// File: rtl/gf22_sram64_ctrl_pkg.sv
// Shared constants and types for the banked 1W1R SRAM controller.
package gf22_sram64_ctrl_pkg;

  localparam int ADDR_W   = 14;
  localparam int DATA_W   = 64;
  localparam int BANK_BIT = 13;
  localparam int ID_W     = 3;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } s1_t;

  // Round-robin successor: the client after idx, wrapping past last.
  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] idx,
                                               input logic [ID_W-1:0] last);
    logic [ID_W-1:0] nxt;
    if (idx == last) begin
      nxt = '0;
    end else begin
      nxt = idx + 3'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter
  import gf22_sram64_ctrl_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_idx
);

  localparam int CW = ID_W + 1;

  logic          found_s;
  logic [CW-1:0] cand_s;

  // Scan candidates in priority order ptr, ptr+1, ... modulo N.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int i = 0; i < N; i++) begin
      cand_s = {1'b0, ptr} + CW'(i);
      if (cand_s >= CW'(N)) begin
        cand_s = cand_s - CW'(N);
      end else begin
        cand_s = cand_s;
      end
      for (int j = 0; j < N; j++) begin
        if (!found_s && req[j] && (cand_s == CW'(j))) begin
          gnt[j]  = 1'b1;
          gnt_idx = ID_W'(j);
          found_s = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
    end
  end

endmodule

// File: rtl/gf22_sram64_be_ctrl.sv
// Multi-client controller for the 16K x 64 banked 1W1R SRAM: round-robin
// arbitration per port, same-bank conflict resolution, fixed-latency responses.
module gf22_sram64_be_ctrl
  import gf22_sram64_ctrl_pkg::*;
#(
  parameter int NR = 2,
  parameter int NW = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NR-1:0]        rd_valid,
  input  logic [NR*14-1:0]     rd_addr,
  output logic [NR-1:0]        rd_ready,
  output logic                 rsp_valid,
  output logic [2:0]           rsp_id,
  output logic [63:0]          rsp_data,
  input  logic [NW-1:0]        wr_valid,
  input  logic [NW*14-1:0]     wr_addr,
  input  logic [NW*64-1:0]     wr_data,
  input  logic [NW*64-1:0]     wr_wem,
  output logic [NW-1:0]        wr_ready,
  output logic                 CE0,
  output logic [13:0]          A0,
  output logic [63:0]          D0,
  output logic                 WE0,
  output logic [63:0]          WEM0,
  output logic                 CE1,
  output logic [13:0]          A1,
  input  logic [63:0]          Q1
);

  logic [ID_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ID_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic              conf_last_q, conf_last_d;
  s1_t               s1_q, s1_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic [NR-1:0]     rd_gnt_s;
  logic [NW-1:0]     wr_gnt_s;
  logic [ID_W-1:0]   rd_idx_s, wr_idx_s;
  logic [ADDR_W-1:0] rd_win_addr_s, wr_win_addr_s;
  logic [DATA_W-1:0] wr_win_data_s, wr_win_wem_s;
  logic              conflict_s, rd_go_s, wr_go_s;

  rr_arbiter #(.N(NR)) u_rd_arb (
    .req     (rd_valid),
    .ptr     (rd_ptr_q),
    .gnt     (rd_gnt_s),
    .gnt_idx (rd_idx_s)
  );

  rr_arbiter #(.N(NW)) u_wr_arb (
    .req     (wr_valid),
    .ptr     (wr_ptr_q),
    .gnt     (wr_gnt_s),
    .gnt_idx (wr_idx_s)
  );

  // Select the winners' request fields from the flattened client buses.
  always_comb begin
    rd_win_addr_s = '0;
    wr_win_addr_s = '0;
    wr_win_data_s = '0;
    wr_win_wem_s  = '0;
    for (int j = 0; j < NR; j++) begin
      if (rd_gnt_s[j]) begin
        rd_win_addr_s = rd_addr[j*ADDR_W +: ADDR_W];
      end else begin
        rd_win_addr_s = rd_win_addr_s;
      end
    end
    for (int j = 0; j < NW; j++) begin
      if (wr_gnt_s[j]) begin
        wr_win_addr_s = wr_addr[j*ADDR_W +: ADDR_W];
        wr_win_data_s = wr_data[j*DATA_W +: DATA_W];
        wr_win_wem_s  = wr_wem[j*DATA_W +: DATA_W];
      end else begin
        wr_win_addr_s = wr_win_addr_s;
        wr_win_data_s = wr_win_data_s;
        wr_win_wem_s  = wr_win_wem_s;
      end
    end
  end

  // conf_last_q=1 hands the next same-bank tie to the write side, so the
  // two sides alternate and neither loses twice in a row.
  always_comb begin
    conflict_s = (|rd_gnt_s) && (|wr_gnt_s) &&
                 (rd_win_addr_s[BANK_BIT] == wr_win_addr_s[BANK_BIT]);
    rd_go_s    = (|rd_gnt_s) && !RST && !(conflict_s && conf_last_q);
    wr_go_s    = (|wr_gnt_s) && !RST && !(conflict_s && !conf_last_q);

    rd_ready = rd_go_s ? rd_gnt_s : '0;
    wr_ready = wr_go_s ? wr_gnt_s : '0;
    CE0      = wr_go_s;
    WE0      = wr_go_s;
    A0       = wr_go_s ? wr_win_addr_s : '0;
    D0       = wr_go_s ? wr_win_data_s : '0;
    WEM0     = wr_go_s ? wr_win_wem_s  : '0;
    CE1      = rd_go_s;
    A1       = rd_go_s ? rd_win_addr_s : '0;
  end

  // Next-state for pointers, tie-break bit and the response pipeline.
  always_comb begin
    rd_ptr_d    = rd_go_s ? next_ptr(rd_idx_s, ID_W'(NR - 1)) : rd_ptr_q;
    wr_ptr_d    = wr_go_s ? next_ptr(wr_idx_s, ID_W'(NW - 1)) : wr_ptr_q;
    conf_last_d = (conflict_s && !RST) ? ~conf_last_q : conf_last_q;
    s1_d.valid  = rd_go_s;
    s1_d.id     = rd_go_s ? rd_idx_s : '0;
    rsp_valid_d = s1_q.valid;
    rsp_id_d    = s1_q.id;
    rsp_data_d  = Q1;
  end

  // State registers; reset drops any in-flight read.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      conf_last_q <= 1'b0;
      s1_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      conf_last_q <= conf_last_d;
      s1_q        <= s1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_gf22_sram64_be_ctrl.sv
// Scoreboard bench for gf22_sram64_be_ctrl with a behavioural 1W1R SRAM.
module tb_gf22_sram64_be_ctrl;

  localparam int NR = 2;
  localparam int NW = 2;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NR-1:0]     rd_valid, rd_ready;
  logic [NR*14-1:0]  rd_addr;
  logic              rsp_valid;
  logic [2:0]        rsp_id;
  logic [63:0]       rsp_data;
  logic [NW-1:0]     wr_valid, wr_ready;
  logic [NW*14-1:0]  wr_addr;
  logic [NW*64-1:0]  wr_data, wr_wem;
  logic              CE0, WE0, CE1;
  logic [13:0]       A0, A1;
  logic [63:0]       D0, WEM0, Q1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [63:0] sram    [16384];
  logic [63:0] ref_mem [16384];

  typedef struct {
    logic [2:0]  id;
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] last_rsp_data = 64'd0;

  gf22_sram64_be_ctrl #(.NR(NR), .NW(NW)) dut (
    .CLK(CLK), .RST(RST),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_wem(wr_wem), .wr_ready(wr_ready),
    .CE0(CE0), .A0(A0), .D0(D0), .WE0(WE0), .WEM0(WEM0),
    .CE1(CE1), .A1(A1), .Q1(Q1)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // SRAM model: masked write, registered read.
  always @(posedge CLK) begin
    if (CE0 && WE0) sram[A0] <= (sram[A0] & ~WEM0) | (D0 & WEM0);
    if (CE1) Q1 <= sram[A1];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // Monitor: handshake port checks, scoreboard push on accept, pop on response.
  always @(negedge CLK) begin : mon
    logic [13:0] a;
    logic [63:0] d, m;
    exp_t        e;
    if (RST) begin
      chk("rst_rd_ready", 64'(rd_ready), 64'd0);
      chk("rst_wr_ready", 64'(wr_ready), 64'd0);
      chk("rst_ce", 64'({CE0, WE0, CE1}), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (rd_valid[i] && rd_ready[i]) begin
          a = rd_addr[i*14 +: 14];
          chk("rd_ce1", 64'(CE1), 64'd1);
          chk("rd_a1", 64'(A1), 64'(a));
          e.id = 3'(i);
          e.data = ref_mem[a];
          e.due = cyc + 2;
          sb_q.push_back(e);
        end
      end
      for (int i = 0; i < NW; i++) begin
        if (wr_valid[i] && wr_ready[i]) begin
          a = wr_addr[i*14 +: 14];
          d = wr_data[i*64 +: 64];
          m = wr_wem[i*64 +: 64];
          chk("wr_ce_we", 64'({CE0, WE0}), 64'd3);
          chk("wr_a0", 64'(A0), 64'(a));
          chk("wr_d0", D0, d);
          chk("wr_wem0", WEM0, m);
          ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
        end
      end
      if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
        e = sb_q.pop_front();
        chk("rsp_missing", 64'(cyc), 64'(e.due));
      end
      if (rsp_valid) begin
        if (sb_q.size() == 0) begin
          chk("rsp_unexp", 64'(sb_q.size()), 64'd1);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_id", 64'(rsp_id), 64'(e.id));
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_lat", 64'(cyc), 64'(e.due));
          last_rsp_data = rsp_data;
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_wr(input int c, input logic [13:0] a, input logic [63:0] d, input logic [63:0] m);
    logic ok;
    ok = 1'b0;
    wr_addr[c*14 +: 14] = a;
    wr_data[c*64 +: 64] = d;
    wr_wem[c*64 +: 64]  = m;
    wr_valid[c] = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge CLK);
      ok = wr_ready[c];
      step();
    end
    wr_valid[c] = 1'b0;
    chk("wr_tmo", 64'(ok), 64'd1);
  endtask

  task automatic do_rd(input int c, input logic [13:0] a);
    logic ok;
    ok = 1'b0;
    rd_addr[c*14 +: 14] = a;
    rd_valid[c] = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge CLK);
      ok = rd_ready[c];
      step();
    end
    rd_valid[c] = 1'b0;
    chk("rd_tmo", 64'(ok), 64'd1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20 && sb_q.size() != 0; k++) step();
    step();
    chk("idle_tmo", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    RST = 1'b1;
    rd_valid = '0; wr_valid = '0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; wr_wem = '0;
    Q1 = 64'd0;
    for (int k = 0; k < 16384; k++) begin
      sram[k] = 64'd0;
      ref_mem[k] = 64'd0;
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    step();
    RST = 1'b0;
    step();

    // Single write then read, checked for data and two-edge latency.
    do_wr(0, 14'h0005, 64'hDEAD_BEEF_0123_4567, {64{1'b1}});
    do_rd(0, 14'h0005);
    wait_idle();
    chk("t1_data", last_rsp_data, 64'hDEAD_BEEF_0123_4567);

    // Masked write keeps the upper half.
    do_wr(0, 14'h2001, {64{1'b1}}, {64{1'b1}});
    do_wr(0, 14'h2001, 64'd0, 64'h0000_0000_FFFF_FFFF);
    do_rd(0, 14'h2001);
    wait_idle();
    chk("mask_data", last_rsp_data, 64'hFFFF_FFFF_0000_0000);

    // Client 1 read moves rd_ptr back to 0, then round-robin alternation.
    do_rd(1, 14'h0050);
    wait_idle();
    rd_addr = {14'h0040, 14'h0030};
    rd_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      chk("rr_gnt", 64'(rd_ready), ((k % 2) == 0) ? 64'd1 : 64'd2);
      step();
    end
    rd_valid = '0;
    wait_idle();

    // Same-bank read/write: alternating winners, read first.
    rd_addr[13:0] = 14'h0010;
    wr_addr[13:0] = 14'h0020;
    wr_data[63:0] = 64'hA5A5_5A5A_0F0F_F0F0;
    wr_wem[63:0]  = {64{1'b1}};
    rd_valid[0] = 1'b1;
    wr_valid[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      chk("cf_rd", 64'(rd_ready[0]), 64'((k % 2) == 0));
      chk("cf_wr", 64'(wr_ready[0]), 64'((k % 2) == 1));
      step();
    end
    // Different banks: both proceed every cycle.
    wr_addr[13:0] = 14'h2010;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("nb_rd", 64'(rd_ready[0]), 64'd1);
      chk("nb_wr", 64'(wr_ready[0]), 64'd1);
      step();
    end
    rd_valid = '0;
    wr_valid = '0;
    wait_idle();

    // Same address in one cycle: read wins and sees old data.
    do_wr(0, 14'h0100, 64'h1111_1111_1111_1111, {64{1'b1}});
    rd_addr[13:0] = 14'h0100;
    wr_addr[13:0] = 14'h0100;
    wr_data[63:0] = 64'h2222_2222_2222_2222;
    rd_valid[0] = 1'b1;
    wr_valid[0] = 1'b1;
    @(negedge CLK);
    chk("same_rd_first", 64'(rd_ready[0]), 64'd1);
    chk("same_wr_wait", 64'(wr_ready[0]), 64'd0);
    step();
    rd_valid[0] = 1'b0;
    @(negedge CLK);
    chk("same_wr_next", 64'(wr_ready[0]), 64'd1);
    step();
    wr_valid[0] = 1'b0;
    wait_idle();
    chk("same_old", last_rsp_data, 64'h1111_1111_1111_1111);
    do_rd(0, 14'h0100);
    wait_idle();
    chk("same_new", last_rsp_data, 64'h2222_2222_2222_2222);

    // Reset with reads in flight: responses dropped, pointers back to 0.
    rd_addr = {14'h0040, 14'h0030};
    rd_valid = 2'b11;
    step();
    step();
    RST = 1'b1;
    sb_q.delete();
    @(negedge CLK);
    chk("rst_mid_ce", 64'({CE0, CE1}), 64'd0);
    step();
    RST = 1'b0;
    wr_addr = {14'h2040, 14'h2030};
    wr_data = {64'h0BAD_0BAD_0BAD_0BAD, 64'h0C0C_0C0C_0C0C_0C0C};
    wr_wem  = {128{1'b1}};
    wr_valid = 2'b11;
    @(negedge CLK);
    chk("rst_rd_ptr", 64'(rd_ready), 64'd1);
    chk("rst_wr_ptr", 64'(wr_ready), 64'd1);
    step();
    rd_valid = '0;
    wr_valid = '0;
    wait_idle();
    repeat (4) step();
    chk("end_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
